eth_mii_rx: RTL and testbench
=============================

# eth_mii_rx

Receive front end of the SoC Ethernet MAC: samples an MII nibble stream on a clock-enable strobe and detects preamble/SFD. It assembles bytes low nibble first, strips the 4-byte FCS through a delay line, checks CRC-32, and classifies the frame. It feeds the Ethernet receive buffer behind the APB peripheral bus with a byte stream plus a per-frame status pulse and statistics counters.

## Interface
- MIN_FRAME_BYTES, 64: shortest legal frame in bytes, including FCS.
- MAX_FRAME_BYTES, 1518: longest legal frame in bytes, including FCS.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- mii_en_i  in  1  nibble strobe; MII inputs are sampled only when it is 1.
- mii_rx_dv_i  in  1  MII receive data valid.
- mii_rxd_i  in  4  MII receive nibble.
- mii_rx_er_i  in  1  MII receive error.
- rx_data_o  out  8  payload byte, FCS excluded.
- rx_valid_o  out  1  one-cycle qualifier for rx_data_o; no backpressure.
- rx_last_o  out  1  marks the final payload byte; only valid with rx_valid_o.
- frame_done_o  out  1  one-cycle end-of-frame status strobe.
- frame_ok_o  out  1  no error flags set; valid with frame_done_o.
- frame_len_o  out  11  byte count including FCS, saturating at 2047.
- crc_err_o, len_err_o, align_err_o, mii_err_o  out  1 each  error flags, valid with frame_done_o.
- frames_ok_cnt_o, frames_bad_cnt_o  out  16 each  saturating frame counters.

## Operation
- All outputs reset to 0. The FSM resets to IDLE with seen_low=0.
- Every FSM step happens only on a cycle with mii_en_i=1.
- IDLE: setting seen_low requires sampling dv=0. With seen_low=1 and dv=1, go to PREAMBLE.
  - A frame already in progress when reset releases is therefore ignored entirely.
- PREAMBLE:
  - dv=0: go to IDLE.
  - Nibble 0x5: stay.
  - Nibble 0xD: go to DATA; clear the CRC, length, nibble phase, delay line and error flags.
  - Any other nibble: go to DROP.
- DROP: wait for dv=0, then go to IDLE. No status pulse and no counter update.
- DATA, while dv=1:
  - Even-phase nibble: store it as the low nibble.
  - Odd-phase nibble: complete a byte and:
    - update CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF);
    - increment the length, saturating;
    - push the byte into the 5-deep delay line. If the line was already full, emit the oldest byte (rx_valid_o=1, rx_last_o=0).
  - mii_rx_er_i=1 sets the sticky mii_err flag.
  - Length above MAX_FRAME_BYTES sets len_err; reception continues.
- DATA, on dv=0 (end of frame):
  - If the delay line holds 5 bytes, emit the oldest byte with rx_last_o=1. The remaining 4 are the FCS and are discarded.
  - Assert frame_done_o with the flags:
    - crc_err: the CRC register is not equal to residue 0xDEBB20E3;
    - len_err: length below MIN or above MAX;
    - align_err: nibble phase is odd (the trailing nibble is dropped);
    - frame_ok_o: the NOR of all four flags.
  - Increment exactly one counter; counters saturate at 0xFFFF.
  - Go to IDLE with seen_low=1.
- Frames shorter than 5 bytes emit no data. The status pulse still fires.
- Data from bad frames is still emitted; the downstream buffer discards it on frame_ok_o=0.

## Timing
- All outputs are registered; each is updated in the cycle after the sampling clk edge with mii_en_i=1.
- Byte latency: the payload byte completed at nibble-strobe k appears 5 byte-completions later.
  - Exception: the last payload byte appears at the end-of-frame strobe.
- rx_last_o and frame_done_o coincide in the same cycle when payload is non-empty.
- rx_valid_o, rx_last_o and frame_done_o are single-cycle pulses. They are never asserted on consecutive cycles unless mii_en_i is continuously 1.
- A reset asserted mid-frame aborts without a status pulse. Counters clear.
- mii_en_i=0 holds all state; pulse outputs return to 0.

## Structure
- eth_pkg holds:
  - the state enum (IDLE, PREAMBLE, DATA, DROP);
  - CRC_POLY, CRC_INIT and CRC_RESIDUE constants;
  - the SFD and preamble nibble constants;
  - a packed rx_status_t struct (len, the four flags, ok), shared with the receive buffer.
- Sub-module eth_crc32: byte-wide CRC register with clear, enable, 8-bit data and 32-bit state.

## Test plan
- 64-byte good frame (7×0x55, 0xD5, 60 payload bytes 0x00..0x3B, correct FCS), mii_en_i every 2nd cycle:
  - 60 rx_valid_o pulses carrying 0x00..0x3B, with rx_last_o on 0x3B;
  - frame_done_o with len=64, frame_ok_o=1, frames_ok_cnt_o=1.
- Same frame with one payload bit flipped: data identical, crc_err_o=1, frame_ok_o=0, frames_bad_cnt_o=1.
- 60-byte frame with valid FCS: 56 data bytes; len_err_o=1, crc_err_o=0, len=60.
- Good 64-byte frame plus one extra nibble: align_err_o=1, len=64.
- Preamble nibble 0x3 before the SFD: no data, no frame_done_o, counters unchanged. The next good frame is received correctly.
- rst pulsed after byte 20, with dv still high: no output for the remainder of that frame. The next frame after a dv low gap is received with frame_ok_o=1.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types, constants and the CRC-32 byte step for the MII receive path.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_e;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  // Per-frame status word, also consumed by the receive buffer.
  typedef struct packed {
    logic [10:0] len;
    logic        crc_err;
    logic        len_err;
    logic        align_err;
    logic        mii_err;
    logic        ok;
  } rx_status_t;

  // One reflected CRC-32 step over a byte, LSB first, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = {1'b0, c[31:1]} ^ CRC_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 register: clear loads the init value, enable folds in one byte.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next CRC value: clear has priority over a data update.
  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc32_byte(crc_q, data_i);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/eth_mii_rx.sv
// MII receive front end: preamble/SFD detection, byte assembly, FCS stripping
// through a 5-byte delay line, CRC-32 check, frame classification and counters.
module eth_mii_rx
  import eth_pkg::*;
#(
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mii_en_i,
  input  logic        mii_rx_dv_i,
  input  logic [3:0]  mii_rxd_i,
  input  logic        mii_rx_er_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        rx_last_o,
  output logic        frame_done_o,
  output logic        frame_ok_o,
  output logic [10:0] frame_len_o,
  output logic        crc_err_o,
  output logic        len_err_o,
  output logic        align_err_o,
  output logic        mii_err_o,
  output logic [15:0] frames_ok_cnt_o,
  output logic [15:0] frames_bad_cnt_o
);

  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_BYTES);

  // Receive state
  rx_state_e       state_q, state_d;
  logic            seen_low_q, seen_low_d;
  logic [3:0]      low_nib_q, low_nib_d;
  logic            phase_q, phase_d;
  logic [10:0]     len_q, len_d;
  logic [4:0][7:0] dl_q, dl_d;
  logic [2:0]      dl_cnt_q, dl_cnt_d;
  logic            mii_err_q, mii_err_d;

  // Registered outputs
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_last_q, rx_last_d;
  logic            done_q, done_d;
  rx_status_t      status_q, status_d;
  logic [15:0]     ok_cnt_q, ok_cnt_d;
  logic [15:0]     bad_cnt_q, bad_cnt_d;

  // CRC interface
  logic            crc_clr_s;
  logic            crc_en_s;
  logic [7:0]      byte_s;
  logic [31:0]     crc_s;

  // End-of-frame classification from the current state
  logic            eof_crc_err_s;
  logic            eof_len_err_s;
  logic            eof_ok_s;

  assign byte_s        = {mii_rxd_i, low_nib_q};
  assign eof_crc_err_s = (crc_s != CRC_RESIDUE);
  assign eof_len_err_s = (len_q < MIN_LEN) || (len_q > MAX_LEN);
  assign eof_ok_s      = ~(eof_crc_err_s | eof_len_err_s | phase_q | mii_err_q);

  eth_crc32 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (crc_clr_s),
    .en_i   (crc_en_s),
    .data_i (byte_s),
    .crc_o  (crc_s)
  );

  // Next-state, datapath and output decode; every step is gated by the nibble strobe.
  always_comb begin
    state_d    = state_q;
    seen_low_d = seen_low_q;
    low_nib_d  = low_nib_q;
    phase_d    = phase_q;
    len_d      = len_q;
    dl_d       = dl_q;
    dl_cnt_d   = dl_cnt_q;
    mii_err_d  = mii_err_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_last_d  = 1'b0;
    done_d     = 1'b0;
    status_d   = status_q;
    ok_cnt_d   = ok_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    crc_clr_s  = 1'b0;
    crc_en_s   = 1'b0;

    if (mii_en_i) begin
      case (state_q)
        IDLE: begin
          // A frame is only accepted after dv has been seen low.
          if (!mii_rx_dv_i) begin
            seen_low_d = 1'b1;
          end else if (seen_low_q) begin
            state_d    = PREAMBLE;
            seen_low_d = 1'b0;
          end else begin
            seen_low_d = seen_low_q;
          end
        end

        PREAMBLE: begin
          if (!mii_rx_dv_i) begin
            state_d    = IDLE;
            seen_low_d = 1'b1;
          end else if (mii_rxd_i == PREAMBLE_NIB) begin
            state_d = PREAMBLE;
          end else if (mii_rxd_i == SFD_NIB) begin
            state_d   = DATA;
            crc_clr_s = 1'b1;
            len_d     = 11'd0;
            phase_d   = 1'b0;
            dl_d      = '0;
            dl_cnt_d  = 3'd0;
            mii_err_d = 1'b0;
          end else begin
            state_d = DROP;
          end
        end

        DATA: begin
          if (mii_rx_dv_i) begin
            if (mii_rx_er_i) begin
              mii_err_d = 1'b1;
            end else begin
              mii_err_d = mii_err_q;
            end
            if (!phase_q) begin
              low_nib_d = mii_rxd_i;
              phase_d   = 1'b1;
            end else begin
              phase_d  = 1'b0;
              crc_en_s = 1'b1;
              if (len_q != 11'h7FF) begin
                len_d = len_q + 11'd1;
              end else begin
                len_d = len_q;
              end
              dl_d = {dl_q[3:0], byte_s};
              // Once full, the line holds exactly the 4 FCS candidates plus one payload byte.
              if (dl_cnt_q == 3'd5) begin
                rx_data_d  = dl_q[4];
                rx_valid_d = 1'b1;
                dl_cnt_d   = dl_cnt_q;
              end else begin
                dl_cnt_d = dl_cnt_q + 3'd1;
              end
            end
          end else begin
            // End of frame: flush the last payload byte, drop the 4 FCS bytes.
            if (dl_cnt_q == 3'd5) begin
              rx_data_d  = dl_q[4];
              rx_valid_d = 1'b1;
              rx_last_d  = 1'b1;
            end else begin
              rx_valid_d = 1'b0;
            end
            done_d             = 1'b1;
            status_d.len       = len_q;
            status_d.crc_err   = eof_crc_err_s;
            status_d.len_err   = eof_len_err_s;
            status_d.align_err = phase_q;
            status_d.mii_err   = mii_err_q;
            status_d.ok        = eof_ok_s;
            if (eof_ok_s) begin
              if (ok_cnt_q != 16'hFFFF) begin
                ok_cnt_d = ok_cnt_q + 16'd1;
              end else begin
                ok_cnt_d = ok_cnt_q;
              end
            end else begin
              if (bad_cnt_q != 16'hFFFF) begin
                bad_cnt_d = bad_cnt_q + 16'd1;
              end else begin
                bad_cnt_d = bad_cnt_q;
              end
            end
            state_d    = IDLE;
            seen_low_d = 1'b1;
          end
        end

        DROP: begin
          if (!mii_rx_dv_i) begin
            state_d    = IDLE;
            seen_low_d = 1'b1;
          end else begin
            state_d = DROP;
          end
        end

        default: begin
          state_d    = IDLE;
          seen_low_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      seen_low_q <= 1'b0;
      low_nib_q  <= 4'h0;
      phase_q    <= 1'b0;
      len_q      <= 11'd0;
      dl_q       <= '0;
      dl_cnt_q   <= 3'd0;
      mii_err_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_last_q  <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= '0;
      ok_cnt_q   <= 16'h0000;
      bad_cnt_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      seen_low_q <= seen_low_d;
      low_nib_q  <= low_nib_d;
      phase_q    <= phase_d;
      len_q      <= len_d;
      dl_q       <= dl_d;
      dl_cnt_q   <= dl_cnt_d;
      mii_err_q  <= mii_err_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_last_q  <= rx_last_d;
      done_q     <= done_d;
      status_q   <= status_d;
      ok_cnt_q   <= ok_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign rx_data_o        = rx_data_q;
  assign rx_valid_o       = rx_valid_q;
  assign rx_last_o        = rx_last_q;
  assign frame_done_o     = done_q;
  assign frame_ok_o       = status_q.ok;
  assign frame_len_o      = status_q.len;
  assign crc_err_o        = status_q.crc_err;
  assign len_err_o        = status_q.len_err;
  assign align_err_o      = status_q.align_err;
  assign mii_err_o        = status_q.mii_err;
  assign frames_ok_cnt_o  = ok_cnt_q;
  assign frames_bad_cnt_o = bad_cnt_q;

endmodule

// File: tb/tb_eth_mii_rx.sv
// Scoreboard bench for eth_mii_rx: directed frames, expected bytes/status queued
// at issue time, a negedge monitor pops and compares on every DUT pulse.
module tb_eth_mii_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        mii_en;
  logic        dv;
  logic [3:0]  rxd;
  logic        er;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        frame_done;
  logic        frame_ok;
  logic [10:0] frame_len;
  logic        crc_err;
  logic        len_err;
  logic        align_err;
  logic        mii_err;
  logic [15:0] ok_cnt;
  logic [15:0] bad_cnt;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_byte_t;

  typedef struct {
    logic [10:0] len;
    logic        crc;
    logic        lenr;
    logic        align;
    logic        mii;
    logic        ok;
    logic [15:0] okc;
    logic        unused_pad;
    logic [15:0] badc;
  } exp_stat_t;

  exp_byte_t  exp_bytes[$];
  exp_stat_t  exp_stats[$];
  logic [7:0] frm[$];

  int checks   = 0;
  int failures = 0;
  int ok_m     = 0;
  int bad_m    = 0;

  always #5 clk = ~clk;

  eth_mii_rx dut (
    .clk              (clk),
    .rst              (rst),
    .mii_en_i         (mii_en),
    .mii_rx_dv_i      (dv),
    .mii_rxd_i        (rxd),
    .mii_rx_er_i      (er),
    .rx_data_o        (rx_data),
    .rx_valid_o       (rx_valid),
    .rx_last_o        (rx_last),
    .frame_done_o     (frame_done),
    .frame_ok_o       (frame_ok),
    .frame_len_o      (frame_len),
    .crc_err_o        (crc_err),
    .len_err_o        (len_err),
    .align_err_o      (align_err),
    .mii_err_o        (mii_err),
    .frames_ok_cnt_o  (ok_cnt),
    .frames_bad_cnt_o (bad_cnt)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference FCS over frm[0..n-1]: reflected CRC-32, inverted.
  function automatic logic [31:0] calc_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) begin
        if (c[0]) c = (c >> 1) ^ 32'hEDB8_8320;
        else      c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // Monitor: every DUT pulse is checked against the head of the matching queue.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_bytes.size() == 0) begin
        chk("unexpected_byte", {23'h0, rx_last, rx_data}, 32'hFFFF_FFFF);
      end else begin
        exp_byte_t e;
        e = exp_bytes.pop_front();
        chk("rx_data", rx_data, e.data);
        chk("rx_last", rx_last, e.last);
      end
    end else if (rx_last) begin
      chk("last_without_valid", rx_last, 1'b0);
    end
    if (frame_done) begin
      if (exp_stats.size() == 0) begin
        chk("unexpected_frame_done", frame_len, 32'hFFFF_FFFF);
      end else begin
        exp_stat_t s;
        s = exp_stats.pop_front();
        chk("frame_len", frame_len, s.len);
        chk("crc_err", crc_err, s.crc);
        chk("len_err", len_err, s.lenr);
        chk("align_err", align_err, s.align);
        chk("mii_err", mii_err, s.mii);
        chk("frame_ok", frame_ok, s.ok);
        chk("frames_ok_cnt", ok_cnt, s.okc);
        chk("frames_bad_cnt", bad_cnt, s.badc);
      end
    end
  end

  // One nibble strobe: mii_en high for one cycle, low for the next.
  task automatic nib(input logic v, input logic [3:0] d);
    @(negedge clk);
    mii_en = 1'b1; dv = v; rxd = d; er = 1'b0;
    @(negedge clk);
    mii_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(1'b1, b[3:0]);
    nib(1'b1, b[7:4]);
  endtask

  task automatic idle(input int n);
    repeat (n) nib(1'b0, 4'h0);
  endtask

  task automatic send_preamble();
    repeat (7) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  // Full frame: npay payload bytes 0.. , optional bit flip after FCS, optional extra nibble.
  task automatic run_frame(input int npay, input int flip, input bit extra);
    logic [31:0] fcs;
    logic [7:0]  t;
    exp_stat_t   s;
    int          len;
    frm = {};
    for (int i = 0; i < npay; i++) frm.push_back(i[7:0]);
    fcs = calc_fcs(npay);
    if (flip >= 0) begin
      t = frm[flip / 8];
      t[flip % 8] = ~t[flip % 8];
      frm[flip / 8] = t;
    end
    for (int i = 0; i < npay; i++) exp_bytes.push_back('{data: frm[i], last: (i == npay - 1)});
    len     = npay + 4;
    s.len   = len[10:0];
    s.crc   = (flip >= 0);
    s.lenr  = (len < 64) || (len > 1518);
    s.align = extra;
    s.mii   = 1'b0;
    s.ok    = !(s.crc || s.lenr || s.align);
    if (s.ok) ok_m++; else bad_m++;
    s.okc        = ok_m[15:0];
    s.badc       = bad_m[15:0];
    s.unused_pad = 1'b0;
    exp_stats.push_back(s);
    send_preamble();
    for (int i = 0; i < npay; i++) send_byte(frm[i]);
    for (int i = 0; i < 4; i++) send_byte(fcs[8*i +: 8]);
    if (extra) nib(1'b1, 4'hA);
    idle(3);
  endtask

  initial begin
    rst = 1'b1; mii_en = 1'b0; dv = 1'b0; rxd = 4'h0; er = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_done", frame_done, 1'b0);
    chk("reset_ok_cnt", ok_cnt, 16'h0);
    chk("reset_bad_cnt", bad_cnt, 16'h0);
    chk("reset_status", {frame_len, frame_ok, crc_err, len_err, align_err, mii_err, rx_data}, 32'h0);
    rst = 1'b0;
    idle(4);

    run_frame(60, -1, 1'b0);   // good 64-byte frame
    run_frame(60, 85, 1'b0);   // one payload bit flipped -> CRC error
    run_frame(56, -1, 1'b0);   // 60-byte runt with valid FCS
    run_frame(60, -1, 1'b1);   // extra trailing nibble -> alignment error

    // Bad preamble nibble: whole frame dropped, nothing expected.
    repeat (6) nib(1'b1, 4'h5);
    nib(1'b1, 4'h3);
    for (int i = 0; i < 10; i++) send_byte(i[7:0]);
    idle(3);
    chk("drop_ok_cnt", ok_cnt, 16'd1);
    chk("drop_bad_cnt", bad_cnt, 16'd3);
    run_frame(60, -1, 1'b0);

    // Reset after 20 payload bytes: only the 15 bytes already past the delay line appear.
    frm = {};
    for (int i = 0; i < 30; i++) frm.push_back(i[7:0]);
    for (int i = 0; i < 15; i++) exp_bytes.push_back('{data: frm[i], last: 1'b0});
    send_preamble();
    for (int i = 0; i < 20; i++) send_byte(frm[i]);
    @(negedge clk);
    rst = 1'b1; mii_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ok_m = 0; bad_m = 0;
    chk("rst_ok_cnt", ok_cnt, 16'd0);
    chk("rst_bad_cnt", bad_cnt, 16'd0);
    for (int i = 20; i < 30; i++) send_byte(frm[i]);
    for (int i = 0; i < 4; i++) send_byte(8'hA5);
    idle(3);
    run_frame(60, -1, 1'b0);

    idle(4);
    chk("leftover_bytes", exp_bytes.size(), 32'd0);
    chk("leftover_status", exp_stats.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
